// File: rtl/fetch_stage.sv
// Y86-64 instruction fetch: byte-serial reads from instruction memory, field
// assembly, valP computation and a valid/ready hand-off to decode.
//
// state  | meaning
// S_B0   | request opcode byte at pc, latch icode/ifun, check validity
// S_B1   | request register byte at pc+1
// S_C    | request constant byte k (little-endian), k = 0..7
// S_OUT  | present instruction to decode until accepted
// S_HALT | stopped after halt / invalid / address error
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] imem_addr,
  output logic        imem_rd,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic [63:0] pc
);

  typedef enum logic [2:0] {S_B0, S_B1, S_C, S_OUT, S_HALT} state_t;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [2:0]  r_k;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_ra;
  logic [3:0]  r_rb;
  logic [63:0] r_valc;
  logic [63:0] r_valp;
  logic [2:0]  r_stat;
  logic        r_out_valid;

  function automatic logic f_has_reg(input logic [3:0] c);
    return (c == 4'h2) || (c == 4'h3) || (c == 4'h4) || (c == 4'h5) ||
           (c == 4'h6) || (c == 4'hA) || (c == 4'hB);
  endfunction

  function automatic logic f_has_valc(input logic [3:0] c);
    return (c == 4'h3) || (c == 4'h4) || (c == 4'h5) || (c == 4'h7) || (c == 4'h8);
  endfunction

  function automatic logic f_op_ok(input logic [3:0] c, input logic [3:0] f);
    logic ok;
    case (c)
      4'h2, 4'h7:                                       ok = (f <= 4'd6);
      4'h6:                                             ok = (f <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: ok = (f == 4'd0);
      default:                                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [3:0]  w_op_icode;
  logic [3:0]  w_op_ifun;
  logic        w_has_reg;
  logic        w_has_valc;
  logic [63:0] w_c_base;
  logic [63:0] w_full_len;

  assign w_op_icode = imem_data[7:4];
  assign w_op_ifun  = imem_data[3:0];
  assign w_has_reg  = f_has_reg(r_icode);
  assign w_has_valc = f_has_valc(r_icode);
  // constant bytes start after the register byte when there is one
  assign w_c_base   = w_has_reg ? 64'd2 : 64'd1;
  assign w_full_len = w_has_reg ? 64'd10 : 64'd9;

  always_comb begin
    imem_addr = r_pc;
    case (r_state)
      S_B1:    imem_addr = r_pc + 64'd1;
      S_C:     imem_addr = r_pc + w_c_base + {61'd0, r_k};
      default: imem_addr = r_pc;
    endcase
  end

  assign imem_rd   = !reset && ((r_state == S_B0) || (r_state == S_B1) || (r_state == S_C));
  assign out_valid = r_out_valid;
  assign icode     = r_icode;
  assign ifun      = r_ifun;
  assign rA        = r_ra;
  assign rB        = r_rb;
  assign valC      = r_valc;
  assign valP      = r_valp;
  assign stat      = r_stat;
  assign pc        = r_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_B0;
      r_pc        <= RESET_PC;
      r_k         <= 3'd0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= 4'hF;
      r_rb        <= 4'hF;
      r_valc      <= 64'd0;
      r_valp      <= 64'd0;
      r_stat      <= ST_AOK;
      r_out_valid <= 1'b0;
    end else if (redirect) begin
      // an ack arriving alongside the redirect belongs to the abandoned fetch
      r_state     <= S_B0;
      r_pc        <= redirect_pc;
      r_k         <= 3'd0;
      r_ra        <= 4'hF;
      r_rb        <= 4'hF;
      r_valc      <= 64'd0;
      r_stat      <= ST_AOK;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_B0: begin
          if (imem_ack) begin
            if (imem_err) begin
              r_icode     <= 4'h0;
              r_ifun      <= 4'h0;
              r_ra        <= 4'hF;
              r_rb        <= 4'hF;
              r_valc      <= 64'd0;
              r_valp      <= r_pc;
              r_stat      <= ST_ADR;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_icode <= w_op_icode;
              r_ifun  <= w_op_ifun;
              r_k     <= 3'd0;
              if (!f_op_ok(w_op_icode, w_op_ifun)) begin
                r_ra        <= 4'hF;
                r_rb        <= 4'hF;
                r_valc      <= 64'd0;
                r_valp      <= r_pc + 64'd1;
                r_stat      <= ST_INS;
                r_out_valid <= 1'b1;
                r_state     <= S_OUT;
              end else if (f_has_reg(w_op_icode)) begin
                r_state <= S_B1;
              end else if (f_has_valc(w_op_icode)) begin
                r_state <= S_C;
              end else begin
                r_valp      <= r_pc + 64'd1;
                r_stat      <= (w_op_icode == 4'h0) ? ST_HLT : ST_AOK;
                r_out_valid <= 1'b1;
                r_state     <= S_OUT;
              end
            end
          end
        end
        S_B1: begin
          if (imem_ack) begin
            if (imem_err) begin
              r_ra        <= 4'hF;
              r_rb        <= 4'hF;
              r_valc      <= 64'd0;
              r_valp      <= r_pc;
              r_stat      <= ST_ADR;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_ra <= imem_data[7:4];
              r_rb <= imem_data[3:0];
              if (w_has_valc) begin
                r_k     <= 3'd0;
                r_state <= S_C;
              end else begin
                r_valp      <= r_pc + 64'd2;
                r_out_valid <= 1'b1;
                r_state     <= S_OUT;
              end
            end
          end
        end
        S_C: begin
          if (imem_ack) begin
            if (imem_err) begin
              r_ra        <= 4'hF;
              r_rb        <= 4'hF;
              r_valc      <= 64'd0;
              r_valp      <= r_pc;
              r_stat      <= ST_ADR;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              r_valc[{r_k, 3'b000} +: 8] <= imem_data;
              if (r_k == 3'd7) begin
                r_valp      <= r_pc + w_full_len;
                r_out_valid <= 1'b1;
                r_state     <= S_OUT;
              end else begin
                r_k <= r_k + 3'd1;
              end
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_stat == ST_AOK) begin
              r_pc    <= r_valp;
              r_ra    <= 4'hF;
              r_rb    <= 4'hF;
              r_valc  <= 64'd0;
              r_state <= S_B0;
            end else begin
              r_state <= S_HALT;
            end
          end
        end
        S_HALT: begin
          r_out_valid <= 1'b0;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Y86-64 instruction fetch stage. It sits directly upstream of decode and the register file.
- Reads instruction bytes one per transaction from a byte-wide instruction memory port.
- Parses icode/ifun, the register-specifier byte and the 8-byte constant, and computes valP.
- Hands one complete instruction per transfer to decode over a valid/ready handshake.
- Supports a redirect from later stages (branch, ret) and stops after halt, invalid instruction, or memory error.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high reset
imem_addr  output  64  byte address of current memory request
imem_rd  output  1  read request; held with imem_addr stable until imem_ack
imem_ack  input  1  read completes this cycle; may assert in the first cycle of imem_rd
imem_data  input  8  read byte, valid when imem_ack=1
imem_err  input  1  address error, valid when imem_ack=1
redirect  input  1  one-cycle pulse: abandon current fetch, restart at redirect_pc
redirect_pc  input  64  new PC
out_valid  output  1  instruction fields valid
out_ready  input  1  decode accepts; transfer when out_valid&&out_ready
icode  output  4  instruction code
ifun  output  4  function code
rA  output  4  register A (4'hF if absent)
rB  output  4  register B (4'hF if absent)
valC  output  64  constant, little-endian assembled (0 if absent)
valP  output  64  PC of next sequential instruction
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
pc  output  64  address of instruction being fetched/held

Behaviour:
- States: S_B0 (opcode byte), S_B1 (register byte), S_C (constant bytes, 3-bit counter k=0..7), S_OUT (present to decode), S_HALT.
- imem_rd=1 only in S_B0/S_B1/S_C and never while reset=1.
- imem_addr is pc in S_B0, pc+1 in S_B1, and pc+(has_reg?2:1)+k in S_C.
- Reset: state=S_B0, pc=RESET_PC, out_valid=0, icode=0, ifun=0, rA=rB=4'hF, valC=0, valP=0, stat=1. Fetch starts the cycle after reset deasserts.
- Lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte
  - 2 cmov, 6 OPq, A push, B pop: 2 bytes (reg byte)
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes (reg byte + valC)
  - 7 jXX, 8 call: 9 bytes (valC only)
- Validity check at the S_B0 ack:
  - INS if icode>4'hB.
  - INS if icode=6 and ifun>3.
  - INS if icode=2 or 7 and ifun>6.
  - INS if any other icode has ifun!=0.
- S_B0 ack:
  - Latch icode/ifun.
  - Invalid: go to S_OUT with stat=4, rA=rB=F, valC=0, valP=pc+1.
  - Otherwise: next state is S_B1 (has_reg), S_C (has_valC only), or S_OUT.
- S_B1 ack: rA=data[7:4], rB=data[3:0]. Next state is S_C if has_valC, else S_OUT.
- S_C ack: valC[8k+7:8k]=data, k++. Go to S_OUT after k=7.
- In S_OUT, valP=pc+length, mod 2^64 wrap.
- imem_err on any ack: go to S_OUT with stat=3, icode/ifun as latched (0 if error on opcode byte), rA=rB=F, valC=0, valP=pc.
- Latency with zero-wait ack: out_valid rises N cycles after entering S_B0, where N = instruction length.
- S_OUT: out_valid=1 and all fields held stable until out_ready.
  - On transfer with stat=1: pc<=valP, state S_B0, out_valid=0 next cycle.
  - On transfer with stat≠1: go to S_HALT.
  - halt (icode 0, valid) reports stat=2.
- S_HALT: out_valid=0, imem_rd=0. Remains there until reset or redirect.
- Redirect (any state, priority below reset):
  - pc<=redirect_pc, state<=S_B0, k<=0, rA/rB/valC cleared, out_valid=0 next cycle.
  - An imem_ack in the same cycle is ignored.
  - A simultaneous out_valid&&out_ready transfer still counts as delivered.
- Reset mid-fetch discards all progress; no partial instruction is ever presented.

Test Plan:
- RESET_PC=0, zero-wait memory with bytes 30 F3 0A 00.. (irmovq $10,%rbx):
  - out_valid on cycle 10 with icode=3, ifun=0, rA=F, rB=3, valC=10, valP=10, stat=1.
- Bytes 60 12 at pc 0x20, out_ready=0 for 3 cycles:
  - icode=6, rA=1, rB=2, valP=0x22 held stable for all 3 cycles.
  - imem_rd=0 while held; next fetch addr 0x22 after accept.
- Byte C0 at pc 0x40:
  - Single output with stat=4, valP=0x41.
  - After accept, stays in S_HALT; imem_rd stays 0 for 20 cycles.
- imem_ack delayed 3 cycles per byte, 7 and 8 then 0x100 (jmp):
  - valC=0x100, valP=pc+9.
  - imem_addr stable during each wait.
- Redirect with redirect_pc=0x80 during S_C of an irmovq:
  - Partial instruction never presented; next imem_addr=0x80.
  - Bytes 00 there yield stat=2, valP=0x81, then halt.
- imem_err on second byte of rrmovq:
  - stat=3, icode=2, rA=rB=F, valC=0, valP=pc; then S_HALT.
  - reset returns to pc=RESET_PC with out_valid=0.
